// File: rtl/risc16_mem_resp_pkg.sv
// Shared types for the risc16 memory responder: loader/run state and byte-lane mapping.
package risc16_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } mem_state_e;

    // Big-endian lanes: even byte address -> bits [15:8], odd -> bits [7:0].
    localparam logic LANE_EVEN = 1'b0;
    localparam logic LANE_ODD  = 1'b1;

    function automatic logic lane_is_hi(input logic addr_bit0);
        return addr_bit0 == LANE_EVEN;
    endfunction

endpackage

// File: rtl/risc16_mem_resp_if.sv
// Bus bundle between the core/loader side and the memory responder.
interface risc16_mem_resp_if;

    logic [15:0] iaddr;
    logic        ioe;
    logic [15:0] idin;
    logic [15:0] daddr;
    logic        doe;
    logic        dwe0;
    logic        dwe1;
    logic [15:0] ddout;
    logic [15:0] ddin;
    logic        cpu_rst;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_ovf;

    modport master (
        output iaddr, ioe, daddr, doe, dwe0, dwe1, ddout,
        output ld_start, ld_valid, ld_data, ld_last,
        input  idin, ddin, cpu_rst, ld_ready, ld_ovf
    );

    modport slave (
        input  iaddr, ioe, daddr, doe, dwe0, dwe1, ddout,
        input  ld_start, ld_valid, ld_data, ld_last,
        output idin, ddin, cpu_rst, ld_ready, ld_ovf
    );

endinterface

// File: rtl/risc16_mem_resp_array.sv
// 2**AW x 16 word array: two asynchronous read ports, one write port with byte enables.
module risc16_mem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we_hi,
    input  logic          we_lo,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [15:0]   rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [15:0]   rdata_b
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we_hi) mem[waddr][15:8] <= wdata[15:8];
        if (we_lo) mem[waddr][7:0]  <= wdata[7:0];
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/risc16_mem_resp.sv
// Memory responder for the risc16 core: byte-stream loader holding the core in reset,
// then shared instruction/data word memory with big-endian byte strobes.
module risc16_mem_resp
    import risc16_mem_pkg::*;
#(
    parameter int AW       = 10,
    parameter int RST_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    risc16_mem_resp_if.slave bus
);

    localparam int PW = AW + 1;
    localparam int CW = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

    mem_state_e    state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic          full, full_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ovf, ovf_nxt;
    logic          cpu_rst_q;

    logic          we_hi, we_lo;
    logic [AW-1:0] waddr;
    logic [15:0]   wdata;
    logic [15:0]   irdata;

    logic unused_bits;
    assign unused_bits = ^{bus.iaddr, bus.daddr, bus.ioe, bus.doe};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            ptr       <= '0;
            full      <= 1'b0;
            cnt       <= '0;
            ovf       <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            full      <= full_nxt;
            cnt       <= cnt_nxt;
            ovf       <= ovf_nxt;
            cpu_rst_q <= (state_nxt != ST_RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        full_nxt  = full;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        we_hi     = 1'b0;
        we_lo     = 1'b0;
        waddr     = ptr[AW:1];
        wdata     = {bus.ld_data, bus.ld_data};

        unique case (state)
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    // 'full' marks that the last byte slot is already written,
                    // so the saturated pointer never rewrites it.
                    if (!full) begin
                        we_hi = lane_is_hi(ptr[0]);
                        we_lo = !lane_is_hi(ptr[0]);
                        if (ptr == '1) full_nxt = 1'b1;
                        else           ptr_nxt  = ptr + PW'(1);
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                    if (bus.ld_last) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = CW'(RST_HOLD);
                    end
                end
            end
            ST_HOLD: begin
                if (cnt == CW'(1)) state_nxt = ST_RUN;
                cnt_nxt = cnt - CW'(1);
            end
            ST_RUN: begin
                we_hi = bus.dwe0;
                we_lo = bus.dwe1;
                waddr = bus.daddr[AW:1];
                wdata = bus.ddout;
                if (bus.ld_start) begin
                    state_nxt = ST_LOAD;
                    ptr_nxt   = '0;
                    full_nxt  = 1'b0;
                    ovf_nxt   = 1'b0;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    risc16_mem_array #(.AW(AW)) u_array (
        .clk     (clk),
        .we_hi   (we_hi),
        .we_lo   (we_lo),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (bus.iaddr[AW:1]),
        .rdata_a (irdata),
        .raddr_b (bus.daddr[AW:1]),
        .rdata_b (bus.ddin)
    );

    assign bus.idin     = cpu_rst_q ? 16'h0000 : irdata;
    assign bus.cpu_rst  = cpu_rst_q;
    assign bus.ld_ready = (state == ST_LOAD);
    assign bus.ld_ovf   = ovf;

endmodule

// File: doc/risc16_mem_resp.md
Name: risc16_mem_resp

Overview:
Memory-side responder for the risc16 instruction and data buses. It serves instruction fetches and data loads/stores from one shared word array, with big-endian byte lanes. It also contains a byte-stream loader that fills the array while holding the core in reset, then releases it. It sits between the testbench/board loader and the risc16 core in the top level.

Parameters:
AW, 10, word-address width; array holds 2**AW 16-bit words (byte space 2**(AW+1)).
RST_HOLD, 4, cycles cpu_rst stays high after the final loader byte is accepted (>=1).

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  reset; asynchronous, active-low.
iaddr  in  16  instruction byte address from core; bits [AW:1] index the array.
ioe  in  1  instruction output enable; ignored, fetch is always served.
idin  out  16  instruction word to core, combinational.
daddr  in  16  data byte address from core.
doe  in  1  data read enable; ignored for read, only used by the bench.
dwe0  in  1  write strobe for bits [15:8] (even byte).
dwe1  in  1  write strobe for bits [7:0] (odd byte).
ddout  in  16  store data from core.
ddin  out  16  data word to core, combinational.
cpu_rst  out  1  registered, active-high synchronous reset for the core.
ld_start  in  1  pulse; requests a reload while in RUN.
ld_valid  in  1  loader byte valid.
ld_data  in  8  loader byte.
ld_last  in  1  marks final byte; sampled with ld_valid.
ld_ready  out  1  loader may transfer.
ld_ovf  out  1  sticky: a byte was offered past the end of the array.

Behaviour:
- Reset (rst_n=0, asynchronous): state=LOAD; cpu_rst=1; byte pointer=0; hold counter=0; ld_ovf=0. The array is not cleared.
- States are LOAD, HOLD and RUN.
- LOAD:
  - ld_ready=1.
  - Transfer occurs when ld_valid && ld_ready. The byte is written at pointer p: word p[AW:1]. Even p writes [15:8]; odd p writes [7:0]. Then p increments.
  - When p = 2**(AW+1)-1 has just been written, p saturates. Later bytes are dropped, ld_ovf is set, and ld_ready stays 1 so the stream drains.
  - A transfer with ld_last moves to HOLD (the byte is written, if in range). The hold counter loads RST_HOLD.
  - ld_start is ignored.
- HOLD:
  - ld_ready=0; cpu_rst=1.
  - The counter decrements each cycle. At counter==1, go to RUN.
  - Result: cpu_rst falls on the edge exactly RST_HOLD cycles after the ld_last-accept edge.
- RUN:
  - cpu_rst=0; ld_ready=0.
  - Core writes are enabled. On posedge, dwe0 writes ddout[15:8] and dwe1 writes ddout[7:0] into word daddr[AW:1]. Both strobes together give a full-word write.
  - ld_start=1 moves to LOAD: cpu_rst=1 on the next edge, p=0, ld_ovf cleared.
- Core strobes (dwe0/dwe1) outside RUN are ignored.
- Reads:
  - idin = mem[iaddr[AW:1]] while cpu_rst=0; 16'h0000 (NOP) while cpu_rst=1.
  - ddin = mem[daddr[AW:1]] always, combinational, zero latency. Write-then-read shows new data from the cycle after the write edge.
  - Address bits above AW alias; bit 0 is ignored for word access (byte select is done by the core).
- Simultaneous instruction read and data write to the same word returns the old value in that cycle.
- rst_n asserted in any state aborts the current operation and returns to the reset state above.

Decomposition:
- Package risc16_mem_pkg: state enum (LOAD, HOLD, RUN), byte-lane constants (even=upper, odd=lower).
- One sub-module, risc16_mem_array: 2**AW x 16 array with two async read ports and one write port with two byte enables. The loader/core write mux and the FSM stay in the parent.

Test Plan:
1. Reset, then stream 0x12, 0x34, 0x56, 0x78 (last on 0x78) -> mem[0]=0x1234 and mem[1]=0x5678; cpu_rst falls exactly RST_HOLD cycles after the last accept; then iaddr=0x0002 gives idin=0x5678, and idin=0x0000 before release.
2. RUN, daddr=0x0004, dwe0=dwe1=1, ddout=0xBEEF -> next cycle ddin=0xBEEF at daddr=0x0004.
3. RUN, daddr=0x0005, dwe1 only, ddout=0x00AA -> word=0xBEAA; then daddr=0x0004, dwe0 only, ddout=0xCC00 -> word=0xCCAA.
4. During LOAD, pulse dwe0=dwe1=1 at daddr=0x0000 with ddout=0xFFFF -> mem[0] unchanged (still the loader value).
5. With AW=2, send 9 bytes without last -> first 8 fill mem[0..3], ld_ovf=1 after the 9th, and the 9th byte is not written anywhere; then ld_last -> HOLD.
6. Assert rst_n=0 mid-load after 3 bytes, then restream from byte 0 -> pointer restarts at 0 and cpu_rst stays 1 throughout. Separately, ld_start in RUN -> cpu_rst=1 on the next edge and ld_ready=1.
